fetch_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline buffer; sits directly upstream of the decode/control stage and produces the 16-bit instruction word that stage consumes as in_buf.
- Owns the PC and issues requests over a req/ack instruction-memory handshake.
- Stalls on the hazard signal, redirects and flushes on a taken branch or jump, and stops fetching after a halt instruction.

---
 rtl/fetch_stage_if.sv | 24 ++
 rtl/fetch_stage.sv | 113 +++++++++++
 tb/tb_fetch_stage.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Instruction-memory req/ack handshake between fetch and memory.
// The fetch stage is the master; memory is the slave.
interface fetch_stage_if #(
    parameter int PC_W = 16
);
    logic            out_imem_req;
    logic [PC_W-1:0] out_imem_addr;
    logic            in_imem_ack;
    logic [15:0]     in_imem_data;

    modport master (
        output out_imem_req,
        output out_imem_addr,
        input  in_imem_ack,
        input  in_imem_data
    );

    modport slave (
        input  out_imem_req,
        input  out_imem_addr,
        output in_imem_ack,
        output in_imem_data
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID buffer, redirect and halt handling.
// Optional perf counters are built when FETCH_PERF_EN is defined.
module fetch_stage #(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [15:0]     BUBBLE   = 16'h0000
) (
    input  logic            CLOCK,
    input  logic            in_rst_n,
    input  logic            in_hz,
    input  logic            in_pc_src,
    input  logic [PC_W-1:0] in_target,
    fetch_stage_if.master   imem,
    output logic [15:0]     out_buf,
    output logic [PC_W-1:0] out_pc,
    output logic            out_valid,
    output logic            out_halted
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]     out_fetch_cnt,
    output logic [15:0]     out_stall_cnt
`endif
);

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_REDIR = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;

    logic [1:0]      state;
    logic [PC_W-1:0] pc;
    logic            req;
    logic            accept;
    logic            is_halt;

    // Request only while fetching, unstalled, not redirecting and out of reset.
    always_comb begin
        req     = in_rst_n && (state == S_FETCH) && !in_hz && !in_pc_src;
        accept  = req && imem.in_imem_ack;
        is_halt = (imem.in_imem_data[15:12] == 4'b1111) &&
                  (imem.in_imem_data[3:0] == 4'b0000);
    end

    assign imem.out_imem_req  = req;
    assign imem.out_imem_addr = pc;

    // PC, IF/ID buffer and state update; redirect beats stall beats fetch.
    always_ff @(posedge CLOCK or negedge in_rst_n) begin
        if (!in_rst_n) begin
            pc         <= RESET_PC;
            out_buf    <= BUBBLE;
            out_pc     <= '0;
            out_valid  <= 1'b0;
            out_halted <= 1'b0;
            state      <= S_FETCH;
        end else if (in_pc_src) begin
            pc         <= in_target;
            out_buf    <= BUBBLE;
            out_valid  <= 1'b0;
            out_halted <= 1'b0;
            state      <= S_REDIR;
        end else if (in_hz) begin
            state <= state;
        end else begin
            case (state)
                S_FETCH: begin
                    if (accept) begin
                        out_buf   <= imem.in_imem_data;
                        out_pc    <= pc;
                        out_valid <= 1'b1;
                        pc        <= pc + PC_W'(1);
                        if (is_halt) begin
                            state      <= S_HALT;
                            out_halted <= 1'b1;
                        end
                    end else begin
                        out_buf   <= BUBBLE;
                        out_valid <= 1'b0;
                    end
                end
                S_REDIR: begin
                    state     <= S_FETCH;
                    out_buf   <= BUBBLE;
                    out_valid <= 1'b0;
                end
                S_HALT: begin
                    out_buf   <= BUBBLE;
                    out_valid <= 1'b0;
                end
                default: begin
                    state     <= S_FETCH;
                    out_buf   <= BUBBLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    // Saturating counts of accepted fetches and stalled cycles.
    always_ff @(posedge CLOCK or negedge in_rst_n) begin
        if (!in_rst_n) begin
            out_fetch_cnt <= '0;
            out_stall_cnt <= '0;
        end else begin
            if (accept && (out_fetch_cnt != 16'hFFFF))
                out_fetch_cnt <= out_fetch_cnt + 16'd1;
            if (in_hz && (state != S_HALT) && (out_stall_cnt != 16'hFFFF))
                out_stall_cnt <= out_stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with an expected-output scoreboard.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_fetch_stage;

    localparam logic [15:0] BUB = 16'h0000;

    typedef struct packed {
        logic [15:0] ibuf;
        logic [15:0] pc;
    } exp_t;

    logic        CLOCK = 1'b0;
    logic        in_rst_n;
    logic        in_hz;
    logic        in_pc_src;
    logic [15:0] in_target;
    logic [15:0] out_buf;
    logic [15:0] out_pc;
    logic        out_valid;
    logic        out_halted;
`ifdef FETCH_PERF_EN
    logic [15:0] out_fetch_cnt;
    logic [15:0] out_stall_cnt;
`endif

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];

    fetch_stage_if #(.PC_W(16)) imem ();

    fetch_stage dut (
        .CLOCK      (CLOCK),
        .in_rst_n   (in_rst_n),
        .in_hz      (in_hz),
        .in_pc_src  (in_pc_src),
        .in_target  (in_target),
        .imem       (imem),
        .out_buf    (out_buf),
        .out_pc     (out_pc),
        .out_valid  (out_valid),
        .out_halted (out_halted)
`ifdef FETCH_PERF_EN
        ,
        .out_fetch_cnt (out_fetch_cnt),
        .out_stall_cnt (out_stall_cnt)
`endif
    );

    always #5 CLOCK = ~CLOCK;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic chk_sb(input string tag);
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, ".buf"}, 32'(out_buf), 32'(e.ibuf));
            check({tag, ".pc"}, 32'(out_pc), 32'(e.pc));
            check({tag, ".valid"}, 32'(out_valid), 32'd1);
        end else begin
            check({tag, ".buf"}, 32'(out_buf), 32'(BUB));
            check({tag, ".valid"}, 32'(out_valid), 32'd0);
        end
    endtask

    task automatic drv(input logic ack, input logic [15:0] data);
        imem.in_imem_ack  = ack;
        imem.in_imem_data = data;
    endtask

    task automatic do_reset();
        in_rst_n = 1'b0;
        step();
        step();
        in_rst_n = 1'b1;
    endtask

    initial begin
        in_rst_n  = 1'b0;
        in_hz     = 1'b0;
        in_pc_src = 1'b0;
        in_target = 16'h0000;
        drv(1'b0, 16'h0000);
        step();
        step();
        check("rst.buf", 32'(out_buf), 32'(BUB));
        check("rst.pc", 32'(out_pc), 32'd0);
        check("rst.valid", 32'(out_valid), 32'd0);
        check("rst.halted", 32'(out_halted), 32'd0);
        check("rst.addr", 32'(imem.out_imem_addr), 32'd0);
        check("rst.req", 32'(imem.out_imem_req), 32'd0);
        in_rst_n = 1'b1;

        // zero-wait stream
        drv(1'b1, 16'h0120);
        #1 check("zw.req", 32'(imem.out_imem_req), 32'd1);
        sb.push_back('{16'h0120, 16'h0000});
        step(); chk_sb("zw0");
        drv(1'b1, 16'h0231);
        sb.push_back('{16'h0231, 16'h0001});
        step(); chk_sb("zw1");
        drv(1'b1, 16'h0342);
        sb.push_back('{16'h0342, 16'h0002});
        step(); chk_sb("zw2");
        drv(1'b0, 16'h0000);
        check("zw.addr", 32'(imem.out_imem_addr), 32'd3);
        step(); chk_sb("zw.idle");

        // delayed ack at address 0
        do_reset();
        for (int i = 0; i < 2; i++) begin
            #1 check("dly.req", 32'(imem.out_imem_req), 32'd1);
            step(); chk_sb("dly.wait");
        end
        drv(1'b1, 16'h0120);
        sb.push_back('{16'h0120, 16'h0000});
        step(); chk_sb("dly.acc");
        check("dly.addr", 32'(imem.out_imem_addr), 32'd1);

        // hazard stall for 3 cycles
        in_hz = 1'b1;
        drv(1'b1, 16'hBEEF);
        #1 check("hz.req", 32'(imem.out_imem_req), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("hz.buf", 32'(out_buf), 32'h0120);
            check("hz.valid", 32'(out_valid), 32'd1);
            check("hz.addr", 32'(imem.out_imem_addr), 32'd1);
        end
`ifdef FETCH_PERF_EN
        check("hz.stall_cnt", 32'(out_stall_cnt), 32'd3);
        check("hz.fetch_cnt", 32'(out_fetch_cnt), 32'd1);
`endif

        // redirect during stall with ack high
        in_pc_src = 1'b1;
        in_target = 16'h0040;
        #1 check("br.req", 32'(imem.out_imem_req), 32'd0);
        step(); chk_sb("br.sq");
        check("br.addr", 32'(imem.out_imem_addr), 32'h0040);
        in_pc_src = 1'b0;
        in_hz     = 1'b0;
        drv(1'b1, 16'h0555);
        #1 check("br.redir_req", 32'(imem.out_imem_req), 32'd0);
        step(); chk_sb("br.redir");
        check("br.req2", 32'(imem.out_imem_req), 32'd1);
        sb.push_back('{16'h0555, 16'h0040});
        step(); chk_sb("br.fetch");

        // halt
        drv(1'b1, 16'hF000);
        sb.push_back('{16'hF000, 16'h0041});
        step(); chk_sb("halt.word");
        check("halt.flag", 32'(out_halted), 32'd1);
        for (int i = 0; i < 10; i++) begin
            check("halt.req", 32'(imem.out_imem_req), 32'd0);
            step(); chk_sb("halt.idle");
        end
        check("halt.flag2", 32'(out_halted), 32'd1);
        in_pc_src = 1'b1;
        in_target = 16'h0008;
        step(); chk_sb("halt.br");
        check("halt.clr", 32'(out_halted), 32'd0);
        in_pc_src = 1'b0;
        step(); chk_sb("halt.redir");
        check("halt.res_req", 32'(imem.out_imem_req), 32'd1);
        check("halt.res_addr", 32'(imem.out_imem_addr), 32'h0008);

        // async reset while waiting at FFFF
        drv(1'b0, 16'h0000);
        in_pc_src = 1'b1;
        in_target = 16'hFFFF;
        step(); chk_sb("wr.br");
        in_pc_src = 1'b0;
        step(); chk_sb("wr.redir");
        check("wr.addr", 32'(imem.out_imem_addr), 32'hFFFF);
        step(); chk_sb("wr.wait");
        #2 in_rst_n = 1'b0;
        drv(1'b1, 16'h0999);
        #1;
        check("ar.req", 32'(imem.out_imem_req), 32'd0);
        check("ar.addr", 32'(imem.out_imem_addr), 32'd0);
        check("ar.buf", 32'(out_buf), 32'(BUB));
        check("ar.valid", 32'(out_valid), 32'd0);
`ifdef FETCH_PERF_EN
        check("ar.fetch_cnt", 32'(out_fetch_cnt), 32'd0);
`endif
        step();
        in_rst_n = 1'b1;
        drv(1'b0, 16'h0000);

        // accept at FFFF wraps to 0
        in_pc_src = 1'b1;
        in_target = 16'hFFFF;
        step(); chk_sb("wp.br");
        in_pc_src = 1'b0;
        step(); chk_sb("wp.redir");
        drv(1'b1, 16'h0777);
        sb.push_back('{16'h0777, 16'hFFFF});
        step(); chk_sb("wp.acc");
        check("wp.addr", 32'(imem.out_imem_addr), 32'h0000);
`ifdef FETCH_PERF_EN
        check("wp.fetch_cnt", 32'(out_fetch_cnt), 32'd1);
`endif
        drv(1'b0, 16'h0000);
        step(); chk_sb("wp.idle");
        check("sb.empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
